// File: rtl/fifo_pkg.sv
// Shared types and helpers for the configurable synchronous FIFO.
package fifo_pkg;

  // Read-side behaviour, chosen at elaboration.
  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage: one synchronous write port, one combinational read port.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Storage is deliberately not reset; occupancy tracking guards stale entries.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_cfg.sv
// Synchronous FIFO with selectable standard/FWFT read mode, occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_cfg
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter fifo_mode_e  MODE       = FIFO_FWFT,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CntWidth = ADDR_WIDTH + 1;

  // Elaboration-time parameter sanity checks.
  if (!is_pow2(FIFO_DEPTH)) begin : g_chk_depth
    $error("sync_fifo_cfg: FIFO_DEPTH must be a power of 2");
  end
  if (AF_THRESH > FIFO_DEPTH) begin : g_chk_af
    $error("sync_fifo_cfg: AF_THRESH must not exceed FIFO_DEPTH");
  end
  if (AE_THRESH >= FIFO_DEPTH) begin : g_chk_ae
    $error("sync_fifo_cfg: AE_THRESH must be below FIFO_DEPTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  rd_ok, wr_ok;
  logic                  ovf_set, udf_set;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Status flags decode straight from the registered occupancy.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CntWidth'(FIFO_DEPTH));
  assign almost_full  = (count_q >= CntWidth'(AF_THRESH));
  assign almost_empty = (count_q <= CntWidth'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Flush masks both requests, so a flushed cycle neither moves data nor flags errors.
  assign rd_ok   = !flush && ren && !empty;
  assign wr_ok   = !flush && wen && (!full || rd_ok);
  assign ovf_set = !flush && wen && !wr_ok;
  assign udf_set = !flush && ren && !rd_ok;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, occupancy and sticky error state; a new error beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= ovf_set || (overflow_q && !err_clr);
      underflow_q <= udf_set || (underflow_q && !err_clr);
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr_q),
    .wdata(wdata),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    // Registered read: head word captured on an accepted pop, valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_ok;
        if (rd_ok) rdata_q <= mem_rdata;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end else begin : g_fwft
    // Head word shown directly; zeroed while empty so unreset storage never leaks out.
    assign rdata  = empty ? '0 : mem_rdata;
    assign rvalid = !empty;
  end

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Scoreboard bench for sync_fifo_cfg: one FWFT instance and one standard-mode instance.
module tb_sync_fifo_cfg;
  import fifo_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // FWFT instance signals
  logic          f_flush = 0, f_wen = 0, f_ren = 0, f_err_clr = 0;
  logic [DW-1:0] f_wdata = '0, f_rdata;
  logic          f_full, f_af, f_rvalid, f_empty, f_ae, f_ovf, f_udf;
  logic [5:0]    f_count;

  // Standard-mode instance signals
  logic          s_flush = 0, s_wen = 0, s_ren = 0, s_err_clr = 0;
  logic [DW-1:0] s_wdata = '0, s_rdata;
  logic          s_full, s_af, s_rvalid, s_empty, s_ae, s_ovf, s_udf;
  logic [5:0]    s_count;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sq[$];

  always #5 clk = ~clk;

  sync_fifo_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MODE(FIFO_FWFT)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .wen(f_wen), .wdata(f_wdata),
    .full(f_full), .almost_full(f_af), .ren(f_ren), .rdata(f_rdata), .rvalid(f_rvalid),
    .empty(f_empty), .almost_empty(f_ae), .count(f_count), .err_clr(f_err_clr),
    .overflow(f_ovf), .underflow(f_udf)
  );

  sync_fifo_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MODE(FIFO_STD)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .wen(s_wen), .wdata(s_wdata),
    .full(s_full), .almost_full(s_af), .ren(s_ren), .rdata(s_rdata), .rvalid(s_rvalid),
    .empty(s_empty), .almost_empty(s_ae), .count(s_count), .err_clr(s_err_clr),
    .overflow(s_ovf), .underflow(s_udf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // FWFT monitor: a word is consumed whenever ren meets rvalid.
  always @(negedge clk) begin
    if (rst_n && !f_flush && f_ren && f_rvalid) begin
      if (fq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fwft_unexpected_pop: got 0x%0h, expected no data", f_rdata);
      end else begin
        chk("fwft_rdata", f_rdata, fq.pop_front());
      end
    end
  end

  // Standard-mode monitor: each rvalid pulse carries one word.
  always @(negedge clk) begin
    if (rst_n && s_rvalid) begin
      if (sq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL std_unexpected_rvalid: got 0x%0h, expected no data", s_rdata);
      end else begin
        chk("std_rdata", s_rdata, sq.pop_front());
      end
    end
  end

  task automatic f_write(input logic [DW-1:0] d);
    f_wen = 1; f_wdata = d; fq.push_back(d);
    step();
    f_wen = 0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_count", f_count, 0);
    chk("rst_empty", f_empty, 1);
    chk("rst_full", f_full, 0);
    chk("rst_ae", f_ae, 1);
    chk("rst_af", f_af, 0);
    chk("rst_rvalid", f_rvalid, 0);
    chk("rst_rdata", f_rdata, 0);
    chk("rst_ovf_udf", {f_ovf, f_udf}, 0);
    chk("rst_std_rvalid", s_rvalid, 0);
    chk("rst_std_rdata", s_rdata, 0);
    @(negedge clk);
    rst_n = 1;
    step();

    // Write 1..8 into FWFT; first word visible one edge after its write
    for (int i = 1; i <= 8; i++) begin
      f_write(DW'(i));
      if (i == 1) begin
        chk("fwft_first_rvalid", f_rvalid, 1);
        chk("fwft_first_rdata", f_rdata, 1);
      end
    end
    chk("fill8_count", f_count, 8);
    chk("fill8_empty", f_empty, 0);
    chk("fill8_ae", f_ae, 0);
    f_ren = 1;
    for (int i = 0; i < 8; i++) step();
    f_ren = 0;
    chk("drain8_empty", f_empty, 1);
    chk("drain8_udf", f_udf, 0);

    // Standard mode: three words, three reads, one-cycle latency
    for (int i = 0; i < 3; i++) begin
      s_wen = 1; s_wdata = DW'(8'hA1 + i); sq.push_back(s_wdata);
      step();
    end
    s_wen = 0;
    chk("std_count3", s_count, 3);
    chk("std_rvalid_idle", s_rvalid, 0);
    s_ren = 1;
    for (int i = 0; i < 3; i++) step();
    s_ren = 0;
    chk("std_rvalid_last", s_rvalid, 1);
    step();
    chk("std_rvalid_after", s_rvalid, 0);
    chk("std_empty_after", s_empty, 1);
    chk("std_udf_after", s_udf, 0);
    chk("std_rdata_hold", s_rdata, 8'hA3);

    // Fill FWFT to full, overflow, then simultaneous write+read at full
    for (int i = 0; i < 32; i++) begin
      f_write(DW'(i));
      if (i == 28) chk("af_at29", f_af, 0);
      if (i == 29) chk("af_at30", f_af, 1);
      if (i == 30) chk("full_at31", f_full, 0);
    end
    chk("full_count", f_count, 32);
    chk("full_flag", f_full, 1);
    f_wen = 1; f_wdata = 8'hEE;
    step();
    f_wen = 0;
    chk("ovf_set", f_ovf, 1);
    chk("ovf_count", f_count, 32);
    f_wen = 1; f_wdata = 8'h99; fq.push_back(8'h99); f_ren = 1;
    step();
    f_wen = 0;
    chk("full_rw_count", f_count, 32);
    chk("full_rw_full", f_full, 1);
    for (int i = 0; i < 32; i++) step();
    f_ren = 0;
    chk("wrap_drain_empty", f_empty, 1);
    chk("ovf_sticky", f_ovf, 1);
    f_err_clr = 1;
    step();
    f_err_clr = 0;
    chk("ovf_clr", f_ovf, 0);

    // Simultaneous write+read on empty: write wins, read flags underflow
    f_wen = 1; f_wdata = 8'h55; fq.push_back(8'h55); f_ren = 1;
    step();
    f_wen = 0; f_ren = 0;
    chk("wr_rd_empty_count", f_count, 1);
    chk("wr_rd_empty_udf", f_udf, 1);
    f_err_clr = 1;
    step();
    f_err_clr = 0;
    chk("udf_clr", f_udf, 0);
    chk("udf_clr_rdata", f_rdata, 8'h55);
    chk("udf_clr_count", f_count, 1);
    f_ren = 1;
    step();
    f_ren = 0;

    // Error set beats err_clr; flush keeps error flags
    f_ren = 1; f_err_clr = 1;
    step();
    f_ren = 0; f_err_clr = 0;
    chk("udf_set_wins", f_udf, 1);
    for (int i = 0; i < 10; i++) f_write(DW'(8'h40 + i));
    chk("pre_flush_count", f_count, 10);
    f_flush = 1; f_wen = 1; f_wdata = 8'hDD; fq.delete();
    step();
    f_flush = 0; f_wen = 0;
    chk("flush_count", f_count, 0);
    chk("flush_empty", f_empty, 1);
    chk("flush_rvalid", f_rvalid, 0);
    chk("flush_ovf", f_ovf, 0);
    chk("flush_udf_kept", f_udf, 1);
    f_write(8'h77);
    chk("post_flush_rvalid", f_rvalid, 1);
    chk("post_flush_rdata", f_rdata, 8'h77);
    f_ren = 1;
    step();
    f_ren = 0;
    f_err_clr = 1;
    step();
    f_err_clr = 0;
    chk("udf_clr2", f_udf, 0);
    f_flush = 1; f_ren = 1;
    step();
    f_flush = 0; f_ren = 0;
    chk("flush_ren_no_udf", f_udf, 0);

    // Asynchronous reset mid-burst at count 5
    for (int i = 0; i < 5; i++) f_write(DW'(8'h60 + i));
    chk("pre_rst_count", f_count, 5);
    #2;
    rst_n = 0;
    fq.delete();
    #1;
    chk("async_rst_count", f_count, 0);
    chk("async_rst_empty", f_empty, 1);
    chk("async_rst_rvalid", f_rvalid, 0);
    chk("async_rst_rdata", f_rdata, 0);
    chk("async_rst_ae", f_ae, 1);
    @(negedge clk);
    rst_n = 1;
    step();
    f_write(8'h3C);
    chk("post_rst_rdata", f_rdata, 8'h3C);
    f_ren = 1;
    step();
    f_ren = 0;
    step();
    chk("post_rst_empty", f_empty, 1);

    chk("fwft_queue_drained", fq.size(), 0);
    chk("std_queue_drained", sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_cfg.md
Name: sync_fifo_cfg

Overview:
Parametrised synchronous FIFO, successor to fifo_fwft.
- Read mode selectable at elaboration: standard (registered, 1-cycle read latency) or first-word-fall-through (FWFT).
- Adds full-range occupancy count, almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer/consumer blocks in one clock domain; drop-in for fifo_fwft when MODE=FWFT (count widened by 1 bit).

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
FIFO_DEPTH, 32, number of entries; power of 2, >=2
ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer width (derived, do not override)
MODE, FIFO_FWFT, read mode from fifo_pkg::fifo_mode_e (FIFO_STD or FIFO_FWFT)
AF_THRESH, FIFO_DEPTH-2, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of contents
wen  input  1  write request
wdata  input  DATA_WIDTH  write data
full  output  1  count == FIFO_DEPTH
almost_full  output  1  count >= AF_THRESH
ren  input  1  read request / pop
rdata  output  DATA_WIDTH  read data
rvalid  output  1  rdata valid
empty  output  1  count == 0
almost_empty  output  1  count <= AE_THRESH
count  output  ADDR_WIDTH+1  occupancy, 0..FIFO_DEPTH
err_clr  input  1  clears sticky error flags
overflow  output  1  sticky: write attempted and rejected
underflow  output  1  sticky: read attempted and rejected

Behaviour:
- Reset (rst_n low, async): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rvalid=0, rdata=0, overflow=0, underflow=0. Storage contents are not reset.
- Read accept: rd_ok = ren && !empty.
- Write accept: wr_ok = wen && (!full || rd_ok). A full FIFO with a simultaneous accepted read also accepts the write; count is unchanged.
- Empty FIFO with simultaneous wen and ren: write accepted, read rejected, underflow set, count becomes 1.
- Count: count_next = count + wr_ok - rd_ok. Pointers wrap modulo FIFO_DEPTH. full, empty and the almost flags are decoded combinationally from the registered count.
- Standard mode:
  - rd_ok at edge t -> rdata = head word and rvalid = 1 after edge t (valid for one cycle).
  - rvalid = 0 on cycles with no accepted read; rdata holds its last value.
- FWFT mode:
  - rdata = mem[rd_ptr] combinationally; rvalid = !empty.
  - A write into an empty FIFO at edge t makes rvalid=1 and rdata = that word after edge t.
  - ren with !empty pops; the next word appears after the edge.
- Errors:
  - wen && !wr_ok sets overflow; ren && !rd_ok sets underflow.
  - Both are sticky until err_clr (synchronous).
  - If err_clr and a new error occur in the same cycle, set wins.
  - Rejected operations change no state except the error flags.
- Flush (synchronous): pointers=0, count=0, rvalid=0. Takes priority over wen/ren in the same cycle, which are ignored and raise no errors. Flush does not clear error flags.
- Elaboration checks: $error if FIFO_DEPTH is not a power of 2, or if AF_THRESH > FIFO_DEPTH, or if AE_THRESH >= FIFO_DEPTH.

Decomposition:
- fifo_pkg holds:
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT};
  - function is_pow2() for the parameter check.
- One sub-module, sync_fifo_mem: DATA_WIDTH x FIFO_DEPTH register array.
  - Ports: clk, we, waddr, wdata, raddr, rdata (combinational read).
  - Top level owns pointers, count, flags and mode-specific output staging.

Test Plan:
- Reset then write 1..8 on consecutive cycles with ren=0 -> count=8, empty=0, almost_empty=0; FWFT rdata=1 and rvalid=1 one cycle after the first write.
- STD mode, 3 words queued (0xA1, 0xA2, 0xA3), ren held 3 cycles -> rvalid=1 with rdata 0xA1, 0xA2, 0xA3 on the 3 cycles following each accepted read; then empty=1, rvalid=0, underflow=0.
- Fill 32 words (0..31) -> full=1, almost_full from count=30. Extra wen -> overflow=1, count=32. Then wen+ren together -> count stays 32; read data 0; last written word lands at the wrapped pointer and is read 32nd.
- Empty FIFO, wen=1 with wdata=0x55 and ren=1 in the same cycle -> count=1, underflow=1. err_clr next cycle -> underflow=0, data 0x55 still readable.
- Count=10, assert flush together with wen -> count=0, empty=1, rvalid=0, overflow unchanged. Next write 0x77 appears at rdata (FWFT) after one edge.
- Assert rst_n=0 mid-burst at count=5 -> all outputs take their reset values immediately, without a clock edge; operation resumes cleanly after release.
